// File: rtl/dbg_probe_pkg.sv
// Shared definitions for the Z80 debug bus probe.
//   - probe_state_e : run-control FSM encoding (2 bits)
//   - MREQ_N/M1_N/RD_N/WR_N : bit positions inside the cpu_sig bundle
//   - snap_* helpers : field offsets inside one captured snapshot word,
//     laid out MSB..LSB as {addr, dmaster, dslave, sig}
package dbg_probe_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_STEP   = 2'd2,
    ST_RESUME = 2'd3
  } probe_state_e;

  localparam int MREQ_N = 0;
  localparam int M1_N   = 1;
  localparam int RD_N   = 2;
  localparam int WR_N   = 3;

  // The control bundle occupies the least significant bits, so the
  // snapshot word's low bits double as its sig field.
  localparam int SNAP_OFF_SIG = 0;

  function automatic int snap_off_dslave(input int sig_w);
    return sig_w;
  endfunction

  function automatic int snap_off_dmaster(input int data_w, input int sig_w);
    return sig_w + data_w;
  endfunction

  function automatic int snap_off_addr(input int data_w, input int sig_w);
    return sig_w + 2 * data_w;
  endfunction

  function automatic int snap_width(input int addr_w, input int data_w, input int sig_w);
    return addr_w + 2 * data_w + sig_w;
  endfunction

endpackage

// File: rtl/dbg_btn_edge.sv
// Two-flop synchroniser plus rising-edge detector for a panel button.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   btn_async : raw button level, asynchronous to clk
//   pulse     : one-clock pulse per press; high in the 3rd clock after the
//               button rises so the consumer acts on the 3rd edge
module dbg_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic pulse
);

  // [0] metastability catcher, [1] synchronised level, [2] previous level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn_async};
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Driven purely from flops, so it cannot glitch.
  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/dbg_bus_probe.sv
// Z80 debug bus probe: captures completed memory cycles into a history ring
// readable by depth index, and drives CPU WAIT from a hardware breakpoint,
// an external halt request and the step/run panel buttons.
//   masterclk, rst_n             : clock, asynchronous active-low reset
//   cpu_addr/dmaster/dslave/sig  : live Z80 bus (sig: mreq_n, m1_n, rd_n, wr_n, ...)
//   halt_req, bp_ena, bp_on_m1, bp_addr : halt sources
//   step_btn, run_btn            : asynchronous panel buttons
//   depth_sel                    : 0 = newest capture, k = k-th older
//   cpu_wait_n, halted           : registered run-control outputs
//   view_*                       : selected ring entry, 1-cycle registered readout
//   cycle_count                  : completed bus cycles since reset
module dbg_bus_probe
  import dbg_probe_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int SIG_W  = 8,
  parameter int DEPTH  = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              masterclk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dmaster,
  input  logic [DATA_W-1:0] cpu_dslave,
  input  logic [SIG_W-1:0]  cpu_sig,
  input  logic              halt_req,
  input  logic              bp_ena,
  input  logic              bp_on_m1,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              step_btn,
  input  logic              run_btn,
  input  logic [SEL_W-1:0]  depth_sel,
  output logic              cpu_wait_n,
  output logic              halted,
  output logic [ADDR_W-1:0] view_addr,
  output logic [DATA_W-1:0] view_dmaster,
  output logic [DATA_W-1:0] view_dslave,
  output logic [SIG_W-1:0]  view_sig,
  output logic              view_valid,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int SNAP_W      = snap_width(ADDR_W, DATA_W, SIG_W);
  localparam int OFF_DSLAVE  = snap_off_dslave(SIG_W);
  localparam int OFF_DMASTER = snap_off_dmaster(DATA_W, SIG_W);
  localparam int OFF_ADDR    = snap_off_addr(DATA_W, SIG_W);
  localparam int FILL_W      = SEL_W + 1;

  // Sample stage resets to an idle bus (active-low controls high) so that
  // the first live cycle after reset is not mistaken for an mreq edge.
  localparam logic [SNAP_W-1:0] SNAP_IDLE = SNAP_W'({SIG_W{1'b1}});

  // ---------------- input sample stage ----------------
  logic [SNAP_W-1:0] s1_q, s1_d;
  logic              mreq_fall, mreq_rise, bp_hit;

  always_comb begin
    s1_d = {cpu_addr, cpu_dmaster, cpu_dslave, cpu_sig};
  end

  assign mreq_fall = s1_q[SNAP_OFF_SIG + MREQ_N] & ~cpu_sig[MREQ_N];
  assign mreq_rise = ~s1_q[SNAP_OFF_SIG + MREQ_N] & cpu_sig[MREQ_N];
  assign bp_hit    = bp_ena & ~cpu_sig[MREQ_N] & (cpu_addr == bp_addr)
                   & (~bp_on_m1 | ~cpu_sig[M1_N]);

  // ---------------- capture ring ----------------
  logic [SNAP_W-1:0] ring_q [DEPTH];
  logic [SEL_W-1:0]  wp_q, wp_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    wp_d   = wp_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (mreq_rise) begin
      wp_d   = wp_q + SEL_W'(1);
      fill_d = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + FILL_W'(1);
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the ring itself has no reset; fill_q gates every read, so stale
  // contents are never visible and the array can map onto plain storage.
  always_ff @(posedge masterclk) begin
    if (mreq_rise) begin
      ring_q[wp_q] <= s1_q;
    end
  end

  // ---------------- readout ----------------
  // Reads use the pre-edge pointer and contents, so an entry written on the
  // same edge only becomes visible one clock later.
  logic [SEL_W-1:0]  rd_idx;
  logic              view_valid_q, view_valid_d;
  logic [SNAP_W-1:0] view_q, view_d;

  always_comb begin
    rd_idx       = wp_q - SEL_W'(1) - depth_sel;
    view_valid_d = ({1'b0, depth_sel} < fill_q);
    view_d       = view_valid_d ? ring_q[rd_idx] : '0;
  end

  // ---------------- buttons ----------------
  logic step_pulse, run_pulse;

  dbg_btn_edge u_step_edge (
    .clk       (masterclk),
    .rst_n     (rst_n),
    .btn_async (step_btn),
    .pulse     (step_pulse)
  );

  dbg_btn_edge u_run_edge (
    .clk       (masterclk),
    .rst_n     (rst_n),
    .btn_async (run_btn),
    .pulse     (run_pulse)
  );

  // ---------------- run-control FSM ----------------
  probe_state_e state_q, state_d;
  logic         wait_n_q, wait_n_d;
  logic         halted_q, halted_d;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (bp_hit || halt_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (run_pulse)       state_d = ST_RESUME;
        else if (step_pulse) state_d = ST_STEP;
      end
      ST_STEP: begin
        // The cycle in progress completes; the next one is held at its start.
        if (mreq_fall) state_d = ST_HALT;
      end
      ST_RESUME: begin
        // bp_hit is ignored here so the cycle that halted us can finish.
        if (mreq_rise) state_d = halt_req ? ST_HALT : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    // Outputs come from the next state so they switch on the same edge as
    // the state register, and are themselves registered (glitch-free).
    wait_n_d = (state_d != ST_HALT);
    halted_d = (state_d == ST_HALT);
  end

  // ---------------- state registers ----------------
  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= SNAP_IDLE;
      wp_q         <= '0;
      fill_q       <= '0;
      cnt_q        <= '0;
      view_valid_q <= 1'b0;
      view_q       <= '0;
      state_q      <= ST_RUN;
      wait_n_q     <= 1'b1;
      halted_q     <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      wp_q         <= wp_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      view_valid_q <= view_valid_d;
      view_q       <= view_d;
      state_q      <= state_d;
      wait_n_q     <= wait_n_d;
      halted_q     <= halted_d;
    end
  end

  assign cpu_wait_n   = wait_n_q;
  assign halted       = halted_q;
  assign view_valid   = view_valid_q;
  assign view_addr    = view_q[OFF_ADDR +: ADDR_W];
  assign view_dmaster = view_q[OFF_DMASTER +: DATA_W];
  assign view_dslave  = view_q[OFF_DSLAVE +: DATA_W];
  assign view_sig     = view_q[SNAP_OFF_SIG +: SIG_W];
  assign cycle_count  = cnt_q;

endmodule

// File: doc/dbg_bus_probe.md
Name: dbg_bus_probe

Overview:
- Parametrised successor to the top-level debug hook (single wait level plus 2-bit bank select of live bus values).
- Sits between the Z80 bus and the board debug panel.
- Captures completed memory bus cycles into a history ring that the debug panel reads by depth index.
- Generates CPU WAIT from a hardware address breakpoint, an external halt request, and single-step/run buttons.

Parameters:
- ADDR_W, 16, CPU address width
- DATA_W, 8, CPU data width
- SIG_W, 8, CPU control-signal bundle width
- DEPTH, 8, history ring entries; power of two, >=2
- SEL_W, 3, depth-select width; equals log2(DEPTH)
- CNT_W, 16, bus-cycle counter width

Ports:
- masterclk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  ADDR_W  CPU address bus
- cpu_dmaster  in  DATA_W  CPU data out
- cpu_dslave  in  DATA_W  data returned to the CPU
- cpu_sig  in  SIG_W  control bundle; bit0 mreq_n, bit1 m1_n, bit2 rd_n, bit3 wr_n, others captured only
- halt_req  in  1  level; forces halt from RUN
- bp_ena  in  1  breakpoint enable
- bp_on_m1  in  1  1 = match only on opcode fetch (m1_n=0)
- bp_addr  in  ADDR_W  breakpoint address
- step_btn  in  1  asynchronous button, single-step
- run_btn  in  1  asynchronous button, resume
- depth_sel  in  SEL_W  0 = newest capture, k = k-th older
- cpu_wait_n  out  1  to CPU WAIT pin
- halted  out  1  FSM in HALT
- view_addr  out  ADDR_W  selected entry address
- view_dmaster  out  DATA_W  selected entry master data
- view_dslave  out  DATA_W  selected entry slave data
- view_sig  out  SIG_W  selected entry control bundle
- view_valid  out  1  selected entry has been written since reset
- cycle_count  out  CNT_W  completed bus cycles since reset

Behaviour:
- Reset (async, rst_n=0):
  - cpu_wait_n=1, halted=0, all view_* and cycle_count 0.
  - Ring write pointer 0, fill count 0, FSM=RUN, synchronisers cleared.
- Input sample stage:
  - All cpu_* inputs registered every clock into S1.
  - mreq_fall = S1.mreq_n=1 and live mreq_n=0.
  - mreq_rise = S1.mreq_n=0 and live mreq_n=1.
- Capture:
  - On mreq_rise, write S1 {addr, dmaster, dslave, sig} to ring[wp].
  - Then wp <= wp+1 (wraps at DEPTH) and fill <= min(fill+1, DEPTH).
  - cycle_count += 1; wraps modulo 2^CNT_W.
- Readout:
  - Registered, 1-cycle latency.
  - Index = wp-1-depth_sel modulo DEPTH.
  - view_valid = depth_sel < fill; when 0, view_* data is driven 0.
  - Write and read in the same cycle: the view shows the pre-write content, and the new entry appears the next cycle.
- Buttons:
  - Each goes through a 2-flop synchroniser and rising-edge detect; one pulse per press.
  - Total latency from button to pulse is 3 clocks.
- bp_hit: bp_ena & live mreq_n=0 & cpu_addr==bp_addr & (!bp_on_m1 | m1_n=0).
- FSM states: RUN, HALT, STEP, RESUME.
  - RUN: wait_n=1. bp_hit or halt_req -> HALT. The transition is registered, so wait_n falls 1 clock after the hit, still inside T2 of the matched cycle.
  - HALT: wait_n=0, halted=1.
    - run pulse -> RESUME.
    - Else step pulse -> STEP.
    - Simultaneous pulses: run wins.
    - halt_req is ignored here.
  - STEP: wait_n=1. On mreq_fall (next cycle start) -> HALT, so exactly one further bus cycle completes. Button pulses are ignored.
  - RESUME: wait_n=1. bp_hit is masked until mreq_rise, which prevents re-trigger on the same cycle; then -> RUN. If halt_req=1 at that mreq_rise, -> HALT instead.
- halted and cpu_wait_n are registered outputs derived from the next state.
- No glitches on either output.

Decomposition:
- Package dbg_probe_pkg:
  - FSM state encoding (2 bits).
  - cpu_sig bit-index constants MREQ_N=0, M1_N=1, RD_N=2, WR_N=3.
  - Snapshot record layout (field offsets within the ADDR_W+2*DATA_W+SIG_W word).
- Sub-module dbg_btn_edge (sync + rising-edge pulse), instanced for step_btn and run_btn.
- Ring storage is inferred as a register array in the top module.

Test Plan:
- Reset release, then 3 bus cycles to addr 0x0010/0x0011/0x0012 -> cycle_count=3; depth_sel=0 shows 0x0012 valid; depth_sel=3 gives view_valid=0 and data 0.
- 10 cycles into DEPTH=8 ring, addrs 0x0100..0x0109 -> depth_sel=0 shows 0x0109, depth_sel=7 shows 0x0102, all valid.
- bp_ena=1, bp_addr=0x0066, bp_on_m1=1, read (m1_n=1) of 0x0066 -> no halt; fetch of 0x0066 -> cpu_wait_n=0 one clock after mreq falls, halted=1.
- Halted, then step_btn press -> wait_n=1 after 3 clocks; exactly one bus cycle completes (cycle_count +1); halt again at the next mreq fall.
- Halted at bp 0x0066, run_btn and step_btn pressed the same clock -> RESUME; matched cycle completes without re-halt; later fetch of 0x0066 halts again.
- Mid-HALT, rst_n pulsed low asynchronously -> cpu_wait_n=1 and halted=0 immediately, without waiting for a clock; ring empty, view_valid=0.
